// File: rtl/rf_writeback.sv
// Register-file write front end: merges mem/ALU write requests into an in-order FIFO,
// drains one write per cycle to RegWr/RW/busW, and reports pending writes for hazard checks.
`timescale 1ns/1ps
module rf_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     RegWr,
    output logic [4:0]               RW,
    output logic [31:0]              busW,
    input  logic [4:0]               qA,
    input  logic [4:0]               qB,
    output logic                     busyA,
    output logic                     busyB,
    output logic [31:0]              fwdA,
    output logic [31:0]              fwdB,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    ent_rd_q   [DEPTH];
    logic [4:0]    ent_rd_d   [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          regwr_q, regwr_d;
    logic [4:0]    rw_q, rw_d;
    logic [31:0]   busw_q, busw_d;

    logic [CW-1:0] free;
    logic          mem_enq, alu_enq, pop;
    logic [AW-1:0] alu_slot;

    always_comb begin
        free      = CW'(DEPTH) - count_q;
        mem_ready = (free != '0);
        // Ready depends only on occupancy at the start of the cycle, never on a same-cycle pop.
        alu_ready = (free >= CW'(2)) || ((free != '0) && !mem_valid);
        mem_enq   = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_enq   = alu_valid && alu_ready && (alu_rd != 5'd0);
        pop       = (count_q != '0);

        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        alu_slot   = wr_ptr_q + AW'(mem_enq);
        if (mem_enq) begin
            ent_rd_d[wr_ptr_q]   = mem_rd;
            ent_data_d[wr_ptr_q] = mem_data;
        end
        if (alu_enq) begin
            ent_rd_d[alu_slot]   = alu_rd;
            ent_data_d[alu_slot] = alu_data;
        end

        wr_ptr_d = wr_ptr_q + AW'(mem_enq) + AW'(alu_enq);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);

        regwr_d = pop;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (pop) begin
            rw_d   = ent_rd_q[rd_ptr_q];
            busw_d = ent_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            regwr_q  <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            regwr_q  <= regwr_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
        end
    end

    // Entry storage is only meaningful under count_q, so it needs no reset.
    always_ff @(posedge clock) begin
        ent_rd_q   <= ent_rd_d;
        ent_data_q <= ent_data_d;
    end

    logic [4:0]    qs   [2];
    logic          hit  [2];
    logic [31:0]   hdat [2];
    logic [AW-1:0] idx;

    // Scan output stage first, then FIFO oldest to newest so the newest match wins.
    always_comb begin
        qs[0] = qA;
        qs[1] = qB;
        idx   = '0;
        for (int p = 0; p < 2; p++) begin
            hit[p]  = 1'b0;
            hdat[p] = '0;
            if (qs[p] != 5'd0) begin
                if (regwr_q && (rw_q == qs[p])) begin
                    hit[p]  = 1'b1;
                    hdat[p] = busw_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = rd_ptr_q + AW'(i);
                    if ((CW'(i) < count_q) && (ent_rd_q[idx] == qs[p])) begin
                        hit[p]  = 1'b1;
                        hdat[p] = ent_data_q[idx];
                    end
                end
            end
        end
    end

    assign busyA = hit[0];
    assign busyB = hit[1];
    assign fwdA  = hdat[0];
    assign fwdB  = hdat[1];
    assign RegWr = regwr_q;
    assign RW    = rw_q;
    assign busW  = busw_q;
    assign count = count_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: queue-based reference model plus an independent drain scoreboard.
`timescale 1ns/1ps
module tb_rf_writeback;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]  mem_rd, alu_rd, RW, qA, qB;
    logic [31:0] mem_data, alu_data, busW, fwdA, fwdB;
    logic        RegWr, busyA, busyB;
    logic [$clog2(DEPTH):0] count;

    rf_writeback #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .RegWr(RegWr), .RW(RW), .busW(busW),
        .qA(qA), .qB(qB), .busyA(busyA), .busyB(busyB), .fwdA(fwdA), .fwdB(fwdB),
        .count(count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         model_q[$];
    wr_t         exp_q[$];
    bit          m_out_v = 1'b0;
    logic [4:0]  m_rw = '0;
    logic [31:0] m_busw = '0;
    bit          use_fix = 1'b0;
    logic [4:0]  fix_a = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pending write lookup: newest queued write wins, then the write being presented.
    function automatic logic [32:0] ref_hazard(input logic [4:0] q);
        if (q == 5'd0) return '0;
        for (int i = model_q.size() - 1; i >= 0; i--)
            if (model_q[i].rd == q) return {1'b1, model_q[i].data};
        if (m_out_v && m_rw == q) return {1'b1, m_busw};
        return '0;
    endfunction

    task automatic cycle(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                         input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         output bit macc, output bit aacc);
        int          free;
        bit          emr, ear;
        logic [32:0] ha, hb;
        @(negedge clock);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        qA = use_fix ? fix_a : 5'($urandom_range(0, 8));
        qB = 5'($urandom_range(0, 8));
        #1;
        free = DEPTH - model_q.size();
        emr  = (free >= 1);
        ear  = (free >= 2) || (free >= 1 && !mv);
        ha   = ref_hazard(qA);
        hb   = ref_hazard(qB);
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("count", 32'(count), 32'(model_q.size()));
        chk("RegWr", 32'(RegWr), 32'(m_out_v));
        chk("RW", 32'(RW), 32'(m_rw));
        chk("busW", busW, m_busw);
        chk("busyA", 32'(busyA), 32'(ha[32]));
        chk("fwdA", fwdA, ha[31:0]);
        chk("busyB", 32'(busyB), 32'(hb[32]));
        chk("fwdB", fwdB, hb[31:0]);
        macc = mv && emr;
        aacc = av && ear;
        @(posedge clock);
        if (model_q.size() > 0) begin
            m_out_v = 1'b1;
            m_rw    = model_q[0].rd;
            m_busw  = model_q[0].data;
            void'(model_q.pop_front());
        end else begin
            m_out_v = 1'b0;
        end
        if (macc && mrd != 5'd0) begin
            model_q.push_back('{mrd, md});
            exp_q.push_back('{mrd, md});
        end
        if (aacc && ard != 5'd0) begin
            model_q.push_back('{ard, ad});
            exp_q.push_back('{ard, ad});
        end
    endtask

    task automatic idle();
        bit a, b;
        cycle(1'b0, '0, '0, 1'b0, '0, '0, a, b);
    endtask

    // Drain monitor: every write the DUT presents must be the oldest outstanding accepted write.
    always @(posedge clock) begin
        wr_t e;
        #1;
        if (RegWr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_write: got RW=%0d busW=%0h expected no write", RW, busW);
            end else begin
                e = exp_q.pop_front();
                chk("drain_RW", 32'(RW), 32'(e.rd));
                chk("drain_busW", busW, e.data);
            end
        end
    end

    initial begin
        bit ma, aa;
        int mi, ai;
        mem_valid = 0; alu_valid = 0; mem_rd = 0; alu_rd = 0; mem_data = 0; alu_data = 0;
        qA = 5'd5; qB = 5'd0;
        #1 reset = 1'b1;
        #11;
        chk("rst_RegWr", 32'(RegWr), 0);
        chk("rst_RW", 32'(RW), 0);
        chk("rst_busW", busW, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_mem_ready", 32'(mem_ready), 1);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_busyA", 32'(busyA), 0);
        chk("rst_fwdA", fwdA, 0);
        @(negedge clock);
        reset = 1'b0;

        // single write
        use_fix = 1'b1; fix_a = 5'd5;
        cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'h12345678, ma, aa);
        repeat (4) idle();

        // dual enqueue ordering to the same register
        fix_a = 5'd3;
        cycle(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, ma, aa);
        repeat (4) idle();

        // back-pressure with requests held until accepted
        use_fix = 1'b0;
        mi = 0; ai = 0;
        for (int k = 0; k < 40 && (mi < 4 || ai < 4); k++) begin
            cycle(mi < 4, 5'(2 * mi + 1), 32'h100 + 32'(mi),
                  ai < 4, 5'(2 * ai + 2), 32'h200 + 32'(ai), ma, aa);
            if (ma) mi++;
            if (aa) ai++;
        end
        chk("bp_all_accepted", 32'(mi + ai), 8);
        repeat (6) idle();

        // register zero
        use_fix = 1'b1; fix_a = 5'd0;
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, ma, aa);
        chk("r0_accepted", 32'(aa), 1);
        repeat (3) idle();

        // async reset with three writes queued
        fix_a = 5'd7;
        cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd6, 32'h66, ma, aa);
        cycle(1'b1, 5'd7, 32'h777, 1'b1, 5'd6, 32'h666, ma, aa);
        @(negedge clock);
        mem_valid = 0; alu_valid = 0; qA = 5'd7;
        #2 reset = 1'b1;
        #1;
        chk("arst_RegWr", 32'(RegWr), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_busyA", 32'(busyA), 0);
        chk("arst_fwdA", fwdA, 0);
        model_q.delete();
        exp_q.delete();
        m_out_v = 1'b0; m_rw = '0; m_busw = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) idle();

        // pointer wrap-around with back-to-back single writes
        use_fix = 1'b0;
        for (int i = 0; i < 20; i++)
            cycle(1'b0, '0, '0, 1'b1, 5'(i % 31 + 1), 32'(i), ma, aa);
        repeat (4) idle();

        // randomized traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, ma, aa);
        repeat (8) idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
